// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer and its wait timer.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        NEXT,
        STALL,
        HALTED,
        ERROR
    } state_t;

    localparam logic SEL_INC  = 1'b0;
    localparam logic SEL_INIT = 1'b1;

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts FETCH cycles spent waiting for mem_ack; flags the last allowed cycle.
module fetch_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_terminal
);

    localparam int unsigned W = $clog2(WAIT_MAX + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != W'(WAIT_MAX))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_terminal = (r_cnt == W'(WAIT_MAX - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control FSM: drives the PC mux/enable and the instruction memory handshake.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned CNT_BITS = 16,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stall,
    input  logic                redirect,
    input  logic                halt_req,
    input  logic                mem_ack,
    output logic                sel,
    output logic                increas_en,
    output logic                mem_req,
    output logic                fetch_valid,
    output logic                busy,
    output logic                timeout_err,
    output logic [CNT_BITS-1:0] fetch_count
);

    state_t              r_state;
    state_t              w_next;
    logic                w_adv;
    logic                w_term;
    logic                r_sel;
    logic                r_load_en;
    logic                r_mem_req;
    logic                r_fetch_valid;
    logic                r_busy;
    logic                r_timeout;
    logic [CNT_BITS-1:0] r_count;

    fetch_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      ((w_next == FETCH) && (r_state != FETCH)),
        .i_inc      (r_state == FETCH),
        .o_terminal (w_term)
    );

    always_comb begin
        w_next = r_state;
        w_adv  = 1'b0;
        case (r_state)
            IDLE, HALTED: if (start) w_next = LOAD;
            LOAD:         w_next = FETCH;
            FETCH: begin
                if (mem_ack)     w_next = NEXT;
                else if (w_term) w_next = ERROR;
            end
            NEXT, STALL: begin
                if (halt_req)      w_next = HALTED;
                else if (redirect) w_next = LOAD;
                else if (stall)    w_next = STALL;
                else begin
                    w_next = FETCH;
                    w_adv  = 1'b1;
                end
            end
            ERROR:   w_next = ERROR;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one is a pure state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_sel         <= 1'b0;
            r_load_en     <= 1'b0;
            r_mem_req     <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout     <= 1'b0;
            r_count       <= '0;
        end else begin
            r_state       <= w_next;
            r_sel         <= (w_next == LOAD) ? SEL_INIT : SEL_INC;
            r_load_en     <= (w_next == LOAD);
            r_mem_req     <= (w_next == FETCH);
            r_fetch_valid <= (w_next == NEXT);
            r_busy        <= (w_next == LOAD) || (w_next == FETCH) ||
                             (w_next == NEXT) || (w_next == STALL);
            r_timeout     <= (w_next == ERROR);
            if ((r_state == FETCH) && mem_ack && (r_count != '1)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // The PC+4 step must land on the same edge that re-enters FETCH, so it
    // follows the NEXT/STALL decision rather than a registered state decode.
    assign sel         = r_sel;
    assign increas_en  = r_load_en || w_adv;
    assign mem_req     = r_mem_req;
    assign fetch_valid = r_fetch_valid;
    assign busy        = r_busy;
    assign timeout_err = r_timeout;
    assign fetch_count = r_count;

endmodule
